// File: rtl/natv_axil_bridge.sv
// Native memory bus to AXI4-Lite master bridge with a per-transaction watchdog.
// One request is outstanding at a time. Every output is registered.
module natv_axil_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_awvalid, w_awvalid_next;
  logic        r_wvalid, w_wvalid_next;
  logic        r_bready, w_bready_next;
  logic        r_arvalid, w_arvalid_next;
  logic        r_rready, w_rready_next;
  logic        r_ready, w_ready_next;
  logic        r_timeout, w_timeout_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [3:0]  r_wstrb, w_wstrb_next;
  logic [2:0]  r_arprot, w_arprot_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        w_wd_fire;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_busy;

  assign w_busy = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                  (r_state == S_RADDR) || (r_state == S_RDATA);

  // Counter runs over the whole transaction, not per phase; it fires on its last busy cycle.
  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_wd_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_wd_cnt <= '0;
      end else if (w_busy) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end

    assign w_wd_fire = w_busy && (r_wd_cnt == WD_LAST);
  end else begin : g_no_wd
    assign w_wd_fire = 1'b0;
  end

  // A channel counts as done once its valid has dropped or handshakes this cycle.
  assign w_aw_done = !r_awvalid || mem_axi_awready;
  assign w_w_done  = !r_wvalid  || mem_axi_wready;

  always_comb begin
    w_state_next   = r_state;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_bready_next  = r_bready;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_ready_next   = 1'b0;
    w_timeout_next = 1'b0;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_wstrb_next   = r_wstrb;
    w_arprot_next  = r_arprot;
    w_rdata_next   = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (mem_valid_i) begin
          w_addr_next = mem_addr_i;
          if (mem_wstrb_i != 4'b0000) begin
            w_wdata_next   = mem_wdata_i;
            w_wstrb_next   = mem_wstrb_i;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_state_next   = S_WADDR;
          end else begin
            w_arprot_next  = {mem_instr_i, 2'b00};
            w_arvalid_next = 1'b1;
            w_state_next   = S_RADDR;
          end
        end
      end

      S_WADDR: begin
        if (r_awvalid && mem_axi_awready) w_awvalid_next = 1'b0;
        if (r_wvalid && mem_axi_wready)   w_wvalid_next  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_awvalid_next = 1'b0;
          w_wvalid_next  = 1'b0;
          w_bready_next  = 1'b1;
          w_state_next   = S_WRESP;
        end else if (w_wd_fire) begin
          w_state_next = S_DONE;
        end
      end

      S_WRESP: begin
        if (mem_axi_bvalid) begin
          w_bready_next = 1'b0;
          w_ready_next  = 1'b1;
          w_state_next  = S_DONE;
        end else if (w_wd_fire) begin
          w_state_next = S_DONE;
        end
      end

      S_RADDR: begin
        if (mem_axi_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = S_RDATA;
        end else if (w_wd_fire) begin
          w_state_next = S_DONE;
        end
      end

      S_RDATA: begin
        if (mem_axi_rvalid) begin
          w_rdata_next  = mem_axi_rdata;
          w_rready_next = 1'b0;
          w_ready_next  = 1'b1;
          w_state_next  = S_DONE;
        end else if (w_wd_fire) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides only when the pending handshake did not complete above.
    if (w_wd_fire && (w_state_next == S_DONE) && !w_ready_next) begin
      w_awvalid_next = 1'b0;
      w_wvalid_next  = 1'b0;
      w_bready_next  = 1'b0;
      w_arvalid_next = 1'b0;
      w_rready_next  = 1'b0;
      w_rdata_next   = ERR_RDATA;
      w_timeout_next = 1'b1;
      w_ready_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arprot  <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_bready  <= w_bready_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_ready   <= w_ready_next;
      r_timeout <= w_timeout_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_wstrb   <= w_wstrb_next;
      r_arprot  <= w_arprot_next;
      r_rdata   <= w_rdata_next;
    end
  end

  assign mem_ready_o     = r_ready;
  assign mem_rdata_o     = r_rdata;
  assign timeout_o       = r_timeout;
  assign mem_axi_awvalid = r_awvalid;
  assign mem_axi_awaddr  = r_addr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = r_wvalid;
  assign mem_axi_wdata   = r_wdata;
  assign mem_axi_wstrb   = r_wstrb;
  assign mem_axi_bready  = r_bready;
  assign mem_axi_arvalid = r_arvalid;
  assign mem_axi_araddr  = r_addr;
  assign mem_axi_arprot  = r_arprot;
  assign mem_axi_rready  = r_rready;

endmodule

// File: tb/tb_natv_axil_bridge.sv
// Directed bench for natv_axil_bridge: a delay-programmable AXI-Lite slave and a
// per-cycle monitor run in one process, so sampling order is deterministic.
module tb_natv_axil_bridge;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_valid_i, mem_instr_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        timeout_o;

  natv_axil_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hFFFF_FFFF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_valid_i(mem_valid_i), .mem_instr_i(mem_instr_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave delays: ready/valid asserted this many cycles after the master's valid/ready.
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] r_val;

  int cyc_no, n_ready, ready_cyc, n_timeout, to_at_ready;
  int n_aw_hi, n_w_hi, n_b_hi, n_ar_hi, n_wresp_entry, aw_last, w_last;
  logic [31:0] rdata_at_ready, cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;
  logic        prev_bready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    cyc_no++;
    if (mem_ready_o) begin
      n_ready++;
      ready_cyc      = cyc_no;
      rdata_at_ready = mem_rdata_o;
      to_at_ready    = int'(timeout_o);
    end
    if (timeout_o) n_timeout++;
    if (mem_axi_awvalid) begin
      n_aw_hi++; aw_last = cyc_no;
      cap_awaddr = mem_axi_awaddr; cap_awprot = mem_axi_awprot;
    end
    if (mem_axi_wvalid) begin
      n_w_hi++; w_last = cyc_no;
      cap_wdata = mem_axi_wdata; cap_wstrb = mem_axi_wstrb;
    end
    if (mem_axi_arvalid) begin
      n_ar_hi++; cap_araddr = mem_axi_araddr; cap_arprot = mem_axi_arprot;
    end
    if (mem_axi_bready) n_b_hi++;
    if (mem_axi_bready && !prev_bready) n_wresp_entry++;
    prev_bready = mem_axi_bready;

    if (mem_axi_awvalid) begin mem_axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin mem_axi_awready = 1'b0; aw_cnt = 0; end
    if (mem_axi_wvalid) begin mem_axi_wready = (w_cnt >= w_dly); w_cnt++; end
    else begin mem_axi_wready = 1'b0; w_cnt = 0; end
    if (mem_axi_arvalid) begin mem_axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin mem_axi_arready = 1'b0; ar_cnt = 0; end
    if (mem_axi_bready) begin mem_axi_bvalid = (b_cnt >= b_dly); b_cnt++; end
    else begin mem_axi_bvalid = 1'b0; b_cnt = 0; end
    if (mem_axi_rready) begin mem_axi_rvalid = (r_cnt >= r_dly); r_cnt++; end
    else begin mem_axi_rvalid = 1'b0; r_cnt = 0; end
    mem_axi_rdata = mem_axi_rvalid ? r_val : 32'h0;
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic clear_mon();
    cyc_no = 0; n_ready = 0; ready_cyc = 0; n_timeout = 0; to_at_ready = 0;
    n_aw_hi = 0; n_w_hi = 0; n_b_hi = 0; n_ar_hi = 0; n_wresp_entry = 0;
    aw_last = 0; w_last = 0;
  endtask

  // Issues one request, waits (bounded) for mem_ready_o, then idles two cycles.
  task automatic do_req(input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    clear_mon();
    mem_valid_i = 1'b1; mem_instr_i = instr; mem_addr_i = addr;
    mem_wdata_i = wdata; mem_wstrb_i = wstrb;
    for (int i = 0; i < 40 && n_ready == 0; i++) cyc();
    mem_valid_i = 1'b0; mem_instr_i = 1'b0; mem_wstrb_i = 4'b0;
    cyc();
    cyc();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 32'({mem_ready_o, timeout_o, mem_axi_awvalid, mem_axi_wvalid,
                              mem_axi_bready, mem_axi_arvalid, mem_axi_rready}), 32'h0);
    check({tag, "_data"}, mem_axi_awaddr | mem_axi_araddr | mem_axi_wdata | mem_rdata_o, 32'h0);
    check({tag, "_misc"}, 32'({mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb}), 32'h0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    mem_valid_i = 1'b0; mem_instr_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
    mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b0;
    mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b0; mem_axi_rdata = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; prev_bready = 1'b0;
    r_val = '0;
    set_dly(0, 0, 0, 0, 0);
    clear_mon();
    #1;
    check_outputs_zero("reset");
    cyc(); cyc();
    rst_n_i = 1'b1;
    cyc(); cyc();

    // Plain read, zero-wait slave
    r_val = 32'h1234_5678;
    do_req(1'b0, 32'h0300_5004, 32'h0, 4'b0000);
    check("rd_araddr", cap_araddr, 32'h0300_5004);
    check("rd_arprot", 32'(cap_arprot), 32'h0);
    check("rd_latency", ready_cyc, 3);
    check("rd_rdata", rdata_at_ready, 32'h1234_5678);
    check("rd_ready_cnt", n_ready, 1);
    check("rd_no_timeout", n_timeout, 0);
    $display("read  addr=0x03005004 rdata=0x%08h lat=%0d", rdata_at_ready, ready_cyc);

    // Instruction fetch
    r_val = 32'h0BAD_F00D;
    do_req(1'b1, 32'h3000_0000, 32'h0, 4'b0000);
    check("if_arprot", 32'(cap_arprot), 32'h4);
    check("if_araddr", cap_araddr, 32'h3000_0000);
    check("if_rdata", rdata_at_ready, 32'h0BAD_F00D);
    $display("fetch addr=0x30000000 arprot=%0d rdata=0x%08h", cap_arprot, rdata_at_ready);

    // Write, address accepted two cycles before data
    set_dly(0, 2, 0, 0, 0);
    do_req(1'b0, 32'h0300_1008, 32'hDEAD_BEEF, 4'b0011);
    check("wr1_awaddr", cap_awaddr, 32'h0300_1008);
    check("wr1_awprot", 32'(cap_awprot), 32'h0);
    check("wr1_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("wr1_wstrb", 32'(cap_wstrb), 32'h3);
    check("wr1_aw_hi", n_aw_hi, 1);
    check("wr1_w_hi", n_w_hi, 3);
    check("wr1_w_last", w_last, 3);
    check("wr1_latency", ready_cyc, 5);
    check("wr1_ready_cnt", n_ready, 1);
    check("wr1_rdata_hold", rdata_at_ready, 32'h0BAD_F00D);
    $display("write addr=0x03001008 aw_hi=%0d w_hi=%0d lat=%0d", n_aw_hi, n_w_hi, ready_cyc);

    // Write, both channels delayed to a same-cycle handshake, slow B
    set_dly(3, 3, 2, 0, 0);
    do_req(1'b0, 32'h0300_200C, 32'hCAFE_0001, 4'b1111);
    check("wr2_aw_hi", n_aw_hi, 4);
    check("wr2_w_hi", n_w_hi, 4);
    check("wr2_wresp_entry", n_wresp_entry, 1);
    check("wr2_b_hi", n_b_hi, 3);
    check("wr2_latency", ready_cyc, 8);
    check("wr2_ready_cnt", n_ready, 1);
    check("wr2_no_timeout", n_timeout, 0);
    $display("write addr=0x0300200C b_hi=%0d lat=%0d", n_b_hi, ready_cyc);

    // Slave never accepts the read address: watchdog abort
    set_dly(0, 0, 0, 1000, 0);
    do_req(1'b0, 32'h0300_0040, 32'h0, 4'b0000);
    check("to_ar_hi", n_ar_hi, TO);
    check("to_latency", ready_cyc, TO + 1);
    check("to_pulse_cnt", n_timeout, 1);
    check("to_with_ready", to_at_ready, 1);
    check("to_rdata", rdata_at_ready, 32'hFFFF_FFFF);
    check("to_ready_cnt", n_ready, 1);
    $display("abort addr=0x03000040 ar_hi=%0d rdata=0x%08h", n_ar_hi, rdata_at_ready);

    set_dly(0, 0, 0, 0, 0);
    r_val = 32'h55AA_33CC;
    do_req(1'b0, 32'h0300_0010, 32'h0, 4'b0000);
    check("after_to_latency", ready_cyc, 3);
    check("after_to_rdata", rdata_at_ready, 32'h55AA_33CC);
    check("after_to_no_timeout", n_timeout, 0);
    $display("read  addr=0x03000010 rdata=0x%08h lat=%0d", rdata_at_ready, ready_cyc);

    // Reset while waiting in WRESP
    set_dly(0, 0, 1000, 0, 0);
    clear_mon();
    mem_valid_i = 1'b1; mem_addr_i = 32'h0300_3000; mem_wdata_i = 32'h1111_2222;
    mem_wstrb_i = 4'b1111;
    for (int i = 0; i < 10 && !mem_axi_bready; i++) cyc();
    check("rst_in_wresp", 32'(mem_axi_bready), 32'h1);
    #2;
    rst_n_i = 1'b0;
    mem_valid_i = 1'b0; mem_wstrb_i = 4'b0;
    #1;
    check_outputs_zero("rst_mid");
    cyc(); cyc();
    rst_n_i = 1'b1;
    set_dly(0, 0, 0, 0, 0);
    cyc();
    r_val = 32'h0F0F_1234;
    do_req(1'b0, 32'h0300_0020, 32'h0, 4'b0000);
    check("post_rst_latency", ready_cyc, 3);
    check("post_rst_rdata", rdata_at_ready, 32'h0F0F_1234);
    check("post_rst_araddr", cap_araddr, 32'h0300_0020);
    $display("reset-in-WRESP then read rdata=0x%08h lat=%0d", rdata_at_ready, ready_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
